// File: rtl/sblk_pkg.sv
// Shared widths and FSM state encoding for the SuperBlock row sequencer.
package sblk_pkg;
   localparam int unsigned SBLK_N_TILE       = 40;
   localparam int unsigned SBLK_WID_ACT      = 16;
   localparam int unsigned SBLK_WID_ACTADDR  = 6;
   localparam int unsigned SBLK_WID_WADDR    = 10;
   localparam int unsigned SBLK_WID_PSUMADDR = 9;
   localparam int unsigned SBLK_PSUM_LAT     = 48;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      DRAIN   = 2'd3
   } sblk_state_t;
endpackage

// File: rtl/sblk_ctrl_dly.sv
// Fixed-latency valid+address delay line carrying psum write-backs.
module sblk_ctrl_dly
   import sblk_pkg::*;
#(
   parameter int unsigned DEPTH = SBLK_PSUM_LAT,
   parameter int unsigned WID   = SBLK_WID_PSUMADDR
) (
   input  logic           clk_l,
   input  logic           rst_n,
   input  logic           in_v,
   input  logic [WID-1:0] in_addr,
   output logic           out_v,
   output logic [WID-1:0] out_addr,
   output logic           pend
);
   logic [DEPTH-1:0] v_q;
   logic [WID-1:0]   a_q [DEPTH];

   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) a_q[i] <= '0;
      end else begin
         v_q    <= {v_q[DEPTH-2:0], in_v};
         a_q[0] <= in_addr;
         for (int unsigned i = 1; i < DEPTH; i++) a_q[i] <= a_q[i-1];
      end
   end

   assign out_v    = v_q[DEPTH-1];
   assign out_addr = a_q[DEPTH-1];
   // Entries that will still be in flight after the next edge; the output stage is excluded.
   assign pend     = |v_q[DEPTH-2:0];
endmodule

// File: rtl/sblk_ctrl.sv
// SuperBlock row sequencer: loads activations, then issues weight/act/psum addresses per pass.
module sblk_ctrl
   import sblk_pkg::*;
#(
   parameter int unsigned N_TILE       = SBLK_N_TILE,
   parameter int unsigned WID_ACT      = SBLK_WID_ACT,
   parameter int unsigned WID_ACTADDR  = SBLK_WID_ACTADDR,
   parameter int unsigned WID_WADDR    = SBLK_WID_WADDR,
   parameter int unsigned WID_PSUMADDR = SBLK_WID_PSUMADDR,
   parameter int unsigned PSUM_LAT     = SBLK_PSUM_LAT
) (
   input  logic                    clk_l,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [WID_ACTADDR-2:0]  cfg_act_depth,
   input  logic [WID_PSUMADDR-2:0] cfg_rows,
   input  logic [2*WID_ACT-1:0]    act_in_data,
   input  logic                    act_in_valid,
   output logic                    act_in_ready,
   output logic [2*WID_ACT-1:0]    act_data_out,
   output logic [N_TILE-1:0]       act_wr_en,
   output logic [WID_ACTADDR-2:0]  act_wr_addr_hbit,
   output logic [WID_ACTADDR-2:0]  act_rd_addr_hbit,
   output logic [WID_WADDR-1:0]    w_rd_addr,
   output logic [WID_PSUMADDR-1:0] psum_rd_addr,
   output logic [WID_PSUMADDR-1:0] psum_wr_addr,
   output logic                    psum_wr_en,
   output logic                    busy,
   output logic                    done
);
   localparam int unsigned WD = WID_ACTADDR - 1;
   localparam int unsigned WR = WID_PSUMADDR - 1;
   localparam int unsigned TW = $clog2(N_TILE);
   localparam int unsigned CW = (WR > $clog2(PSUM_LAT)) ? WR : $clog2(PSUM_LAT);
   localparam logic [WID_PSUMADDR-1:0] ZERO_ADDR = '1;

   sblk_state_t            state_q;
   logic [WD-1:0]          d_q, slot_q, pass_q;
   logic [WR-1:0]          r_q;
   logic [TW-1:0]          tile_q;
   logic [CW-1:0]          cyc_q, rows_cw, plen_m1;
   logic [WID_WADDR-1:0]   wbase_q;
   logic                   issue_v_q;
   logic [WID_PSUMADDR-1:0] iss_row_q;
   logic [N_TILE-1:0]      tile_oh;
   logic beat, issue, last_slot, last_tile, last_pass, last_row, pass_end, line_pend;

   // One cycle counter spans a whole pass: values below R are row issues, the rest bubbles.
   always_comb begin
      rows_cw   = CW'(r_q);
      plen_m1   = (rows_cw > CW'(PSUM_LAT)) ? rows_cw - CW'(1) : CW'(PSUM_LAT - 1);
      beat      = act_in_valid && (state_q == LOAD);
      issue     = (state_q == COMPUTE) && (cyc_q < rows_cw);
      last_slot = (slot_q == d_q - WD'(1));
      last_tile = (tile_q == TW'(N_TILE - 1));
      last_pass = (pass_q == d_q - WD'(1));
      last_row  = (cyc_q == rows_cw - CW'(1));
      pass_end  = (cyc_q == plen_m1);
      tile_oh   = {{(N_TILE-1){1'b0}}, 1'b1} << tile_q;
   end

   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         d_q     <= '0;
         r_q     <= '0;
         tile_q  <= '0;
         slot_q  <= '0;
         pass_q  <= '0;
         cyc_q   <= '0;
         wbase_q <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            IDLE: if (start) begin
               d_q     <= cfg_act_depth;
               r_q     <= cfg_rows;
               tile_q  <= '0;
               slot_q  <= '0;
               pass_q  <= '0;
               cyc_q   <= '0;
               wbase_q <= '0;
               state_q <= (cfg_act_depth == '0 || cfg_rows == '0) ? DRAIN : LOAD;
            end
            LOAD: if (beat) begin
               if (last_slot) begin
                  slot_q <= '0;
                  tile_q <= tile_q + TW'(1);
                  if (last_tile) state_q <= COMPUTE;
               end else begin
                  slot_q <= slot_q + WD'(1);
               end
            end
            COMPUTE: begin
               if (pass_end) begin
                  cyc_q   <= '0;
                  pass_q  <= pass_q + WD'(1);
                  wbase_q <= wbase_q + WID_WADDR'(r_q);
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
               if (issue && last_row && last_pass) state_q <= DRAIN;
            end
            DRAIN: if (!issue_v_q && !line_pend) begin
               done    <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         act_wr_en        <= '0;
         act_data_out     <= '0;
         act_wr_addr_hbit <= '0;
         act_rd_addr_hbit <= '0;
         w_rd_addr        <= '0;
         psum_rd_addr     <= '0;
         issue_v_q        <= 1'b0;
         iss_row_q        <= '0;
      end else begin
         act_wr_en <= beat ? tile_oh : '0;
         if (beat) begin
            act_data_out     <= act_in_data;
            act_wr_addr_hbit <= slot_q;
         end
         issue_v_q <= issue;
         iss_row_q <= issue ? WID_PSUMADDR'(cyc_q) : '0;
         if (issue) begin
            act_rd_addr_hbit <= pass_q;
            w_rd_addr        <= wbase_q + WID_WADDR'(cyc_q);
            psum_rd_addr     <= (pass_q == '0) ? ZERO_ADDR : WID_PSUMADDR'(cyc_q);
         end
      end
   end

   sblk_ctrl_dly #(
      .DEPTH (PSUM_LAT),
      .WID   (WID_PSUMADDR)
   ) u_dly (
      .clk_l    (clk_l),
      .rst_n    (rst_n),
      .in_v     (issue_v_q),
      .in_addr  (iss_row_q),
      .out_v    (psum_wr_en),
      .out_addr (psum_wr_addr),
      .pend     (line_pend)
   );

   assign act_in_ready = (state_q == LOAD);
   assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_sblk_ctrl.sv
// Bench for sblk_ctrl: directed corner jobs and randomized jobs checked against a job timeline model.
module tb_sblk_ctrl;
   localparam int N     = 40;
   localparam int LAT   = 48;
   localparam int ZADDR = 511;

   logic        clk_l = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  cfg_act_depth;
   logic [7:0]  cfg_rows;
   logic [31:0] act_in_data;
   logic        act_in_valid;
   logic        act_in_ready;
   logic [31:0] act_data_out;
   logic [39:0] act_wr_en;
   logic [4:0]  act_wr_addr_hbit;
   logic [4:0]  act_rd_addr_hbit;
   logic [9:0]  w_rd_addr;
   logic [8:0]  psum_rd_addr;
   logic [8:0]  psum_wr_addr;
   logic        psum_wr_en;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   sblk_ctrl dut (
      .clk_l            (clk_l),
      .rst_n            (rst_n),
      .start            (start),
      .cfg_act_depth    (cfg_act_depth),
      .cfg_rows         (cfg_rows),
      .act_in_data      (act_in_data),
      .act_in_valid     (act_in_valid),
      .act_in_ready     (act_in_ready),
      .act_data_out     (act_data_out),
      .act_wr_en        (act_wr_en),
      .act_wr_addr_hbit (act_wr_addr_hbit),
      .act_rd_addr_hbit (act_rd_addr_hbit),
      .w_rd_addr        (w_rd_addr),
      .psum_rd_addr     (psum_rd_addr),
      .psum_wr_addr     (psum_wr_addr),
      .psum_wr_en       (psum_wr_en),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk_l = ~clk_l;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_act_wr_en"},   act_wr_en, 0);
      chk({tag, "_act_data"},    act_data_out, 0);
      chk({tag, "_wr_hbit"},     act_wr_addr_hbit, 0);
      chk({tag, "_rd_hbit"},     act_rd_addr_hbit, 0);
      chk({tag, "_w_rd_addr"},   w_rd_addr, 0);
      chk({tag, "_psum_rd"},     psum_rd_addr, 0);
      chk({tag, "_psum_wr"},     psum_wr_addr, 0);
      chk({tag, "_psum_wr_en"},  psum_wr_en, 0);
      chk({tag, "_ready"},       act_in_ready, 0);
      chk({tag, "_busy"},        busy, 0);
      chk({tag, "_done"},        done, 0);
   endtask

   // One job from start to done. Entered and left just after a falling edge.
   // vmode: 0 continuous valid, 1 alternating 1010..., 2 random ~70% valid.
   task automatic run_job(input int d, input int r, input int vmode, input bit poke,
                          input int abort_at);
      int b, tcnt, P, qlast, nlast, q, qw;
      bit pv, seen;
      logic [31:0] pdata;
      chk("idle_busy", busy, 0);
      start         = 1'b1;
      cfg_act_depth = 5'(d);
      cfg_rows      = 8'(r);
      @(negedge clk_l);
      start = 1'b0;

      if (d == 0 || r == 0) begin
         seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            chk("zero_ready", act_in_ready, 0);
            chk("zero_psum_wr_en", psum_wr_en, 0);
            if (done) begin
               seen = 1'b1;
               chk("zero_busy_at_done", busy, 0);
            end else begin
               @(negedge clk_l);
            end
         end
         chk("zero_done_seen", seen, 1);
         @(negedge clk_l);
         chk("zero_done_pulse", done, 0);
         return;
      end

      b = 0; tcnt = 0; pv = 1'b0; pdata = '0;
      forever begin
         if (pv) begin
            chk("act_wr_en", act_wr_en, 64'd1 << (b / d));
            chk("act_wr_hbit", act_wr_addr_hbit, b % d);
            chk("act_data", act_data_out, pdata);
            b++;
         end else begin
            chk("act_wr_idle", act_wr_en, 0);
         end
         if (abort_at != 0 && b == abort_at) begin
            act_in_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            chk_zero("rst_mid");
            @(negedge clk_l);
            rst_n = 1'b1;
            return;
         end
         if (b == N * d) break;
         chk("ready_load", act_in_ready, 1);
         case (vmode)
            0:       pv = 1'b1;
            1:       pv = (tcnt % 2 == 0);
            default: pv = ($urandom_range(0, 9) < 7);
         endcase
         tcnt++;
         pdata        = $urandom;
         act_in_valid = pv;
         act_in_data  = pdata;
         @(negedge clk_l);
      end
      act_in_valid = 1'b0;

      // Issue q = k*P + row lands 2 cycles after the last beat; its write PSUM_LAT later.
      P     = (r > LAT) ? r : LAT;
      qlast = (d - 1) * P + r - 1;
      nlast = 2 + qlast + LAT;
      for (int n = 1; n <= nlast + 2; n++) begin
         q  = n - 2;
         qw = n - 2 - LAT;
         if (q >= 0 && q <= qlast && (q % P) < r) begin
            chk("act_rd_hbit", act_rd_addr_hbit, q / P);
            chk("w_rd_addr", w_rd_addr, ((q / P) * r + q % P) % 1024);
            chk("psum_rd_addr", psum_rd_addr, (q / P == 0) ? ZADDR : q % P);
         end
         if (qw >= 0 && qw <= qlast && (qw % P) < r) begin
            chk("psum_wr_en", psum_wr_en, 1);
            chk("psum_wr_addr", psum_wr_addr, qw % P);
         end else begin
            chk("psum_wr_idle", psum_wr_en, 0);
         end
         chk("done", done, n == nlast + 1);
         chk("busy", busy, n <= nlast);
         chk("ready_off", act_in_ready, 0);
         if (n >= 2) chk("act_wr_off", act_wr_en, 0);
         if (poke && n == 5) begin
            start         = 1'b1;
            cfg_act_depth = 5'($urandom_range(1, 31));
            cfg_rows      = 8'($urandom_range(1, 255));
         end else if (poke && n == 6) begin
            start = 1'b0;
         end
         @(negedge clk_l);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      start         = 1'b0;
      act_in_valid  = 1'b0;
      act_in_data   = '0;
      cfg_act_depth = '0;
      cfg_rows      = '0;
      repeat (2) @(negedge clk_l);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk_l);

      run_job(2, 64, 0, 1'b0, 0);
      run_job(1, 4, 0, 1'b0, 0);
      run_job(1, $urandom_range(1, 20), 1, 1'b0, 0);
      run_job(3, 0, 0, 1'b0, 0);
      run_job(0, 5, 0, 1'b0, 0);
      run_job(2, 10, 0, 1'b1, 0);
      run_job(2, 64, 0, 1'b0, 17);
      run_job(2, $urandom_range(1, 70), 2, 1'b0, 0);
      run_job(5, 255, 0, 1'b0, 0);
      for (int j = 0; j < 4; j++)
         run_job($urandom_range(1, 3), $urandom_range(1, 100), 2, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded time limit, %0d compared / %0d mismatched", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end
endmodule
